regfile_scoreboard: RTL and testbench



---
 rtl/cpu_pkg.sv | 9 +
 rtl/regfile_scoreboard_mux.sv | 33 +++
 rtl/regfile_scoreboard.sv | 77 +++++++
 tb/tb_regfile_scoreboard.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the basic word/address types.
package cpu_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int XZR        = 31;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [63:0]           word_t;
endpackage

// File: rtl/regfile_scoreboard_mux.sv
// Read-port mux hierarchy: mux32to1 is built from two mux16to1 halves and a final 2:1 stage.
module mux16to1 #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] din [16],
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] dout
);
    assign dout = din[sel];
endmodule

module mux32to1 #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] din [32],
    input  logic [4:0]       sel,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] lo_in [16];
    logic [WIDTH-1:0] hi_in [16];
    logic [WIDTH-1:0] lo_out;
    logic [WIDTH-1:0] hi_out;

    for (genvar j = 0; j < 16; j++) begin : g_split
        assign lo_in[j] = din[j];
        assign hi_in[j] = din[j+16];
    end

    mux16to1 #(.WIDTH(WIDTH)) u_lo (.din(lo_in), .sel(sel[3:0]), .dout(lo_out));
    mux16to1 #(.WIDTH(WIDTH)) u_hi (.din(hi_in), .sel(sel[3:0]), .dout(hi_out));

    assign dout = sel[4] ? hi_out : lo_out;
endmodule

// File: rtl/regfile_scoreboard.sv
// 32-entry register file with pending-writeback scoreboard and operand stall request.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = XZR
) (
    input  logic                clk,
    input  logic                reset_n,
    input  reg_addr_t           read_reg1,
    input  reg_addr_t           read_reg2,
    output logic [WIDTH-1:0]    read_data1,
    output logic [WIDTH-1:0]    read_data2,
    input  logic                reg_write,
    input  reg_addr_t           write_reg,
    input  logic [WIDTH-1:0]    write_data,
    input  logic                reserve_en,
    input  reg_addr_t           reserve_reg,
    output logic                stall,
    output logic [NUM_REGS-1:0] pending
);
    logic [WIDTH-1:0] regs [NUM_REGS];
    logic [WIDTH-1:0] stored1;
    logic [WIDTH-1:0] stored2;
    logic             avail1;
    logic             avail2;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
        if (i == ZERO_REG) begin : g_zero
            assign regs[i]    = '0;
            assign pending[i] = 1'b0;
        end else begin : g_reg
            logic [WIDTH-1:0] data_q;
            logic             pend_q;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    data_q <= '0;
                end else if (reg_write && write_reg == reg_addr_t'(i)) begin
                    data_q <= write_data;
                end
            end

            // A reservation in the same cycle as the writeback belongs to a newer instruction.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    pend_q <= 1'b0;
                end else if (reserve_en && reserve_reg == reg_addr_t'(i)) begin
                    pend_q <= 1'b1;
                end else if (reg_write && write_reg == reg_addr_t'(i)) begin
                    pend_q <= 1'b0;
                end
            end

            assign regs[i]    = data_q;
            assign pending[i] = pend_q;
        end
    end

    mux32to1 #(.WIDTH(WIDTH)) u_rd1 (.din(regs), .sel(read_reg1), .dout(stored1));
    mux32to1 #(.WIDTH(WIDTH)) u_rd2 (.din(regs), .sel(read_reg2), .dout(stored2));

`ifdef REGFILE_BYPASS_EN
    assign avail1     = reg_write && (write_reg == read_reg1) && (read_reg1 != reg_addr_t'(ZERO_REG));
    assign avail2     = reg_write && (write_reg == read_reg2) && (read_reg2 != reg_addr_t'(ZERO_REG));
    assign read_data1 = avail1 ? write_data : stored1;
    assign read_data2 = avail2 ? write_data : stored2;
`else
    assign avail1     = 1'b0;
    assign avail2     = 1'b0;
    assign read_data1 = stored1;
    assign read_data2 = stored2;
`endif

    assign stall = (pending[read_reg1] & ~avail1) | (pending[read_reg2] & ~avail2);
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized scoreboard bench for regfile_scoreboard; expectations follow REGFILE_BYPASS_EN.
module tb_regfile_scoreboard;
    typedef struct {
        int          cyc;
        logic [63:0] d1;
        logic [63:0] d2;
        logic        st;
        logic [31:0] pd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  read_reg1 = '0, read_reg2 = '0;
    logic [63:0] read_data1, read_data2;
    logic        reg_write = 1'b0;
    logic [4:0]  write_reg = '0;
    logic [63:0] write_data = '0;
    logic        reserve_en = 1'b0;
    logic [4:0]  reserve_reg = '0;
    logic        stall;
    logic [31:0] pending;

    regfile_scoreboard dut (
        .clk(clk), .reset_n(reset_n),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(read_data1), .read_data2(read_data2),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .reserve_en(reserve_en), .reserve_reg(reserve_reg),
        .stall(stall), .pending(pending)
    );

    always #5 clk = ~clk;

    logic [63:0] mregs [32];
    bit          mpend [32];
    bit          model_known = 0;
    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cycle = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic check(input string name, input int cyc, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, want);
        end
    endtask

    // Monitor: one expectation per checked cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("read_data1", e.cyc, read_data1, e.d1);
            check("read_data2", e.cyc, read_data2, e.d2);
            check("stall",      e.cyc, {63'd0, stall}, {63'd0, e.st});
            check("pending",    e.cyc, {32'd0, pending}, {32'd0, e.pd});
        end
    end

    function automatic logic [63:0] model_read(input logic [4:0] ra, input bit we, input logic [4:0] wr,
                                               input logic [63:0] wd, output bit avail);
        avail = BYPASS && we && (wr == ra) && (ra != 5'd31);
        if (ra == 5'd31) return 64'd0;
        return avail ? wd : mregs[ra];
    endfunction

    task automatic cyc(input bit rn, input bit we, input logic [4:0] wr, input logic [63:0] wd,
                       input bit re, input logic [4:0] rr, input logic [4:0] ra1, input logic [4:0] ra2);
        exp_t e;
        bit   av1, av2;
        @(posedge clk);
        #1;
        cycle++;
        reset_n = rn; reg_write = we; write_reg = wr; write_data = wd;
        reserve_en = re; reserve_reg = rr; read_reg1 = ra1; read_reg2 = ra2;
        if (model_known) begin
            e.cyc = cycle;
            e.d1  = model_read(ra1, we, wr, wd, av1);
            e.d2  = model_read(ra2, we, wr, wd, av2);
            e.st  = (mpend[ra1] && !av1) || (mpend[ra2] && !av2);
            for (int k = 0; k < 32; k++) e.pd[k] = mpend[k];
            exp_q.push_back(e);
        end
        // Architectural effect of the coming edge.
        if (!rn) begin
            for (int k = 0; k < 32; k++) begin
                mregs[k] = '0;
                mpend[k] = 0;
            end
            model_known = 1;
        end else begin
            if (we && wr != 5'd31) begin
                mregs[wr] = wd;
                mpend[wr] = 0;
            end
            if (re && rr != 5'd31) mpend[rr] = 1;
        end
    endtask

    task automatic idle_read(input logic [4:0] ra1, input logic [4:0] ra2);
        cyc(1, 0, 0, 0, 0, 0, ra1, ra2);
    endtask

    initial begin
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        idle_read(5, 0);
        // Reset clears stored data
        cyc(1, 1, 5, 64'hDEAD, 0, 0, 0, 0);
        idle_read(5, 5);
        cyc(0, 0, 0, 0, 0, 0, 5, 5);
        idle_read(5, 5);
        // Basic write/read and zero register
        cyc(1, 1, 3, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0);
        idle_read(3, 3);
        cyc(1, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 31, 3);
        idle_read(31, 31);
        // Scoreboard set/clear
        cyc(1, 0, 0, 0, 1, 7, 0, 0);
        idle_read(0, 7);
        cyc(1, 1, 7, 64'h42, 0, 0, 0, 7);
        idle_read(0, 7);
        cyc(1, 0, 0, 0, 1, 31, 31, 31);
        idle_read(31, 31);
        // Same-cycle write and reserve
        cyc(1, 1, 9, 64'h11, 1, 9, 0, 0);
        idle_read(9, 0);
        // Forwarding window
        cyc(1, 0, 0, 0, 1, 4, 0, 0);
        cyc(1, 1, 4, 64'h99, 0, 0, 4, 0);
        idle_read(4, 4);
        // Reset with reservations and a write in flight
        cyc(1, 0, 0, 0, 1, 2, 0, 0);
        cyc(1, 0, 0, 0, 1, 8, 2, 8);
        cyc(0, 1, 2, 64'h1234, 1, 8, 2, 8);
        idle_read(2, 8);
        // Random traffic
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 63) != 0), $urandom_range(0, 1), 5'($urandom_range(0, 31)),
                {$urandom, $urandom}, $urandom_range(0, 1), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
        idle_read(0, 0);
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
